// File: rtl/connect_recv_endpoint.sv
// CONNECT NoC receive-port sink: per-VC flit FIFOs, peek credits, packet-contiguous drain.
// Optional: RECV_DEST_CHECK_EN adds MY_ID and a sticky dest_err output.
module connect_recv_endpoint #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int NUM_VCS = 2,
  parameter int NUM_RECV_PORTS = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CREDIT_LAT = 2,
`ifdef RECV_DEST_CHECK_EN
  parameter int MY_ID = 0,
`endif
  localparam int VC_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int DEST_BITS = $clog2(NUM_RECV_PORTS),
  localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic                       en_get_flit,
  output logic [NUM_VCS-1:0]         nonfull_vcs,
  output logic                       en_put_nonfull,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLIT_DATA_WIDTH-1:0] out_data,
  output logic                       out_tail,
  output logic [VC_BITS-1:0]         out_vc,
  output logic [DEST_BITS-1:0]       out_dest,
`ifdef RECV_DEST_CHECK_EN
  output logic                       dest_err,
`endif
  output logic                       overflow
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + DEST_BITS + FLIT_DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(BUF_DEPTH - CREDIT_LAT);
  localparam logic [VC_BITS:0] NV = (VC_BITS + 1)'(NUM_VCS);

  logic [ENT_W-1:0] mem_q [NUM_VCS][BUF_DEPTH];
  logic [ENT_W-1:0] mem_d [NUM_VCS][BUF_DEPTH];
  logic [PTR_W-1:0] wptr_q [NUM_VCS];
  logic [PTR_W-1:0] wptr_d [NUM_VCS];
  logic [PTR_W-1:0] rptr_q [NUM_VCS];
  logic [PTR_W-1:0] rptr_d [NUM_VCS];
  logic [CNT_W-1:0] occ_q [NUM_VCS];
  logic [CNT_W-1:0] occ_d [NUM_VCS];
  logic [NUM_VCS-1:0] nonfull_q, nonfull_d;
  logic [NUM_VCS-1:0] empty, push, pop_v;
  logic en_q, en_d;
  logic ovf_q, ovf_d;
  logic lock_q, lock_d;
  logic [VC_BITS-1:0] lock_vc_q, lock_vc_d;
  logic [VC_BITS-1:0] rr_q, rr_d;
  logic [VC_BITS-1:0] sel, cand;
  logic sel_valid, pop, accept, vc_ok, dest_ok;
  logic [ENT_W-1:0] head, entry;

  logic in_valid, in_tail;
  logic [DEST_BITS-1:0] in_dest;
  logic [VC_BITS-1:0] in_vc;

  assign in_valid = flit_in[FLIT_W-1];
  assign in_tail = flit_in[FLIT_W-2];
  assign in_dest = flit_in[FLIT_W-3 -: DEST_BITS];
  assign in_vc = flit_in[FLIT_DATA_WIDTH +: VC_BITS];
  assign entry = {in_tail, in_dest, flit_in[FLIT_DATA_WIDTH-1:0]};
  assign vc_ok = ({1'b0, in_vc} < NV);

`ifdef RECV_DEST_CHECK_EN
  logic derr_q, derr_d;
  assign dest_ok = (in_dest == DEST_BITS'(MY_ID));
  assign dest_err = derr_q;
`else
  assign dest_ok = 1'b1;
`endif

  assign accept = in_valid & dest_ok;

  // Per-VC empty flags from the occupancy counters
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) empty[v] = (occ_q[v] == '0);
  end

  // Head selection: locked VC only, else round-robin from rr_q
  always_comb begin
    sel = rr_q;
    sel_valid = 1'b0;
    cand = '0;
    if (lock_q) begin
      sel = lock_vc_q;
      sel_valid = !empty[lock_vc_q];
    end else begin
      for (int i = NUM_VCS - 1; i >= 0; i--) begin
        cand = VC_BITS'((int'(rr_q) + i) % NUM_VCS);
        if (!empty[cand]) begin
          sel = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign head = mem_q[sel][rptr_q[sel]];
  assign pop = sel_valid & out_ready;

  assign out_valid = sel_valid;
  assign out_tail = sel_valid & head[ENT_W-1];
  assign out_dest = sel_valid ? head[FLIT_DATA_WIDTH +: DEST_BITS] : '0;
  assign out_data = sel_valid ? head[FLIT_DATA_WIDTH-1:0] : '0;
  assign out_vc = sel_valid ? sel : '0;
  assign nonfull_vcs = nonfull_q;
  assign en_get_flit = en_q;
  assign en_put_nonfull = en_q;
  assign overflow = ovf_q;

  // Next state: FIFO push/pop, credits, lock and arbiter pointer
  always_comb begin
    mem_d = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d = occ_q;
    nonfull_d = nonfull_q;
    push = '0;
    pop_v = '0;
    en_d = 1'b1;
    ovf_d = ovf_q;
    lock_d = lock_q;
    lock_vc_d = lock_vc_q;
    rr_d = rr_q;
`ifdef RECV_DEST_CHECK_EN
    derr_d = derr_q | (in_valid & ~dest_ok);
`endif
    if (pop) pop_v[sel] = 1'b1;
    if (accept && !vc_ok) ovf_d = 1'b1;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (accept && in_vc == VC_BITS'(v)) begin
        if (occ_q[v] != FULL || pop_v[v]) push[v] = 1'b1;
        else ovf_d = 1'b1;
      end
      if (push[v]) begin
        mem_d[v][wptr_q[v]] = entry;
        wptr_d[v] = wptr_q[v] + PTR_W'(1);
      end
      if (pop_v[v]) rptr_d[v] = rptr_q[v] + PTR_W'(1);
      if (push[v] && !pop_v[v]) occ_d[v] = occ_q[v] + CNT_W'(1);
      else if (!push[v] && pop_v[v]) occ_d[v] = occ_q[v] - CNT_W'(1);
      nonfull_d[v] = (occ_d[v] < LIM);
    end
    if (pop) begin
      rr_d = VC_BITS'((int'(sel) + 1) % NUM_VCS);
      if (!head[ENT_W-1]) begin
        lock_d = 1'b1;
        lock_vc_d = sel;
      end else begin
        lock_d = 1'b0;
      end
    end
  end

  // Control and pointer registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        occ_q[v] <= '0;
      end
      nonfull_q <= '0;
      en_q <= 1'b0;
      ovf_q <= 1'b0;
      lock_q <= 1'b0;
      lock_vc_q <= '0;
      rr_q <= '0;
`ifdef RECV_DEST_CHECK_EN
      derr_q <= 1'b0;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q <= occ_d;
      nonfull_q <= nonfull_d;
      en_q <= en_d;
      ovf_q <= ovf_d;
      lock_q <= lock_d;
      lock_vc_q <= lock_vc_d;
      rr_q <= rr_d;
`ifdef RECV_DEST_CHECK_EN
      derr_q <= derr_d;
`endif
    end
  end

  // Flit storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_connect_recv_endpoint.sv
// Directed bench for connect_recv_endpoint (default parameters).
// Checks credits, overflow, lock/packet contiguity, round-robin and reset.
module tb_connect_recv_endpoint;

  logic CLK = 1'b0;
  logic RESET;
  logic [36:0] flit_in;
  logic en_get_flit, en_put_nonfull, out_valid, out_ready;
  logic [1:0] nonfull_vcs;
  logic [31:0] out_data;
  logic out_tail, overflow;
  logic [0:0] out_vc;
  logic [1:0] out_dest;
`ifdef RECV_DEST_CHECK_EN
  logic dest_err;
`endif

  int total = 0;
  int bad = 0;

  connect_recv_endpoint dut (
    .CLK(CLK),
    .RESET(RESET),
    .flit_in(flit_in),
    .en_get_flit(en_get_flit),
    .nonfull_vcs(nonfull_vcs),
    .en_put_nonfull(en_put_nonfull),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tail(out_tail),
    .out_vc(out_vc),
    .out_dest(out_dest),
`ifdef RECV_DEST_CHECK_EN
    .dest_err(dest_err),
`endif
    .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  function automatic logic [36:0] mk(input logic t, input logic [1:0] d,
                                     input logic v, input logic [31:0] x);
    return {1'b1, t, d, v, x};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] ord_d [6];
    logic [0:0] ord_v [6];
    ord_d = '{32'h20, 32'h30, 32'h21, 32'h31, 32'h22, 32'h32};
    ord_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    RESET = 1'b1;
    flit_in = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_en_get", 64'(en_get_flit), 64'd0);
    chk("rst_en_put", 64'(en_put_nonfull), 64'd0);
    chk("rst_nonfull", 64'(nonfull_vcs), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);

    RESET = 1'b0;
    tick();
    chk("first_en_get", 64'(en_get_flit), 64'd1);
    chk("first_nonfull", 64'(nonfull_vcs), 64'd3);
    tick();
    tick();
    chk("idle_nonfull", 64'(nonfull_vcs), 64'd3);
    chk("idle_en_put", 64'(en_put_nonfull), 64'd1);
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_ovf", 64'(overflow), 64'd0);

    // single flit latency
    out_ready = 1'b1;
    flit_in = mk(1'b1, 2'd1, 1'b0, 32'hA);
    tick();
    flit_in = '0;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'hA);
    chk("single_tail", 64'(out_tail), 64'd1);
    chk("single_vc", 64'(out_vc), 64'd0);
    chk("single_dest", 64'(out_dest), 64'd1);
    tick();
    chk("single_gone", 64'(out_valid), 64'd0);

    // credits and overflow on VC1
    out_ready = 1'b0;
    flit_in = mk(1'b1, 2'd2, 1'b1, 32'h10);
    tick();
    chk("cred_one", 64'(nonfull_vcs), 64'd3);
    flit_in = mk(1'b1, 2'd2, 1'b1, 32'h11);
    tick();
    chk("cred_two", 64'(nonfull_vcs), 64'd1);
    flit_in = mk(1'b1, 2'd2, 1'b1, 32'h12);
    tick();
    flit_in = mk(1'b1, 2'd2, 1'b1, 32'h13);
    tick();
    chk("full_no_ovf", 64'(overflow), 64'd0);
    flit_in = mk(1'b1, 2'd2, 1'b1, 32'h14);
    tick();
    flit_in = '0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("hold_head", 64'(out_data), 64'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 64'(out_valid), 64'd1);
      chk("drain_data", 64'(out_data), 64'(32'h10 + i));
      chk("drain_vc", 64'(out_vc), 64'd1);
      tick();
    end
    chk("drain_done", 64'(out_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // packet lock: VC0 head, VC1 single in between, VC0 tail later
    flit_in = mk(1'b0, 2'd0, 1'b0, 32'h1);
    tick();
    chk("lock_head", 64'(out_data), 64'h1);
    chk("lock_head_tail", 64'(out_tail), 64'd0);
    flit_in = mk(1'b1, 2'd3, 1'b1, 32'hB);
    tick();
    flit_in = '0;
    chk("lock_gap1", 64'(out_valid), 64'd0);
    tick();
    flit_in = mk(1'b1, 2'd0, 1'b0, 32'h2);
    chk("lock_gap2", 64'(out_valid), 64'd0);
    tick();
    flit_in = '0;
    chk("lock_tail", 64'(out_data), 64'h2);
    chk("lock_tail_flag", 64'(out_tail), 64'd1);
    tick();
    chk("lock_after", 64'(out_data), 64'hB);
    chk("lock_after_vc", 64'(out_vc), 64'd1);
    tick();
    chk("lock_empty", 64'(out_valid), 64'd0);

    // round-robin across both VCs
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flit_in = mk(1'b1, 2'd0, 1'b0, 32'h20 + i);
      tick();
      flit_in = mk(1'b1, 2'd0, 1'b1, 32'h30 + i);
      tick();
    end
    flit_in = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_data", 64'(out_data), 64'(ord_d[i]));
      chk("rr_vc", 64'(out_vc), 64'(ord_v[i]));
      tick();
    end
    chk("rr_empty", 64'(out_valid), 64'd0);

    // reset in the middle of a packet
    out_ready = 1'b0;
    flit_in = mk(1'b0, 2'd1, 1'b0, 32'h40);
    tick();
    flit_in = '0;
    chk("mid_head", 64'(out_valid), 64'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_nonfull", 64'(nonfull_vcs), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    tick();
    chk("mid_nonfull", 64'(nonfull_vcs), 64'd3);
    out_ready = 1'b1;
    flit_in = mk(1'b1, 2'd1, 1'b0, 32'h41);
    tick();
    flit_in = '0;
    chk("mid_tail_valid", 64'(out_valid), 64'd1);
    chk("mid_tail_data", 64'(out_data), 64'h41);
    chk("mid_tail_flag", 64'(out_tail), 64'd1);
    tick();
    chk("mid_alone", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
